// File: rtl/line_adaptor_pkg.sv
// Shared types and parameter helpers for the line/burst adaptor.
package line_adaptor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Number of memory beats that make up one cache line.
    function automatic int unsigned calc_beats(input int unsigned line_width,
                                               input int unsigned burst_width);
        return line_width / burst_width;
    endfunction

    // Beat count must be a power of two and at least 2 so the counter wraps cleanly.
    function automatic bit beats_legal(input int unsigned beats);
        return (beats >= 2) && ((beats & (beats - 1)) == 0);
    endfunction

endpackage

// File: rtl/en_reg.sv
// Load-enabled register with asynchronous active-low clear.
module en_reg #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Load on enable, clear on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/line_burst_adaptor.sv
// Splits a cache-line read/write into a sequence of memory beats and reassembles read data.
module line_burst_adaptor
    import line_adaptor_pkg::*;
#(
    parameter int unsigned LINE_WIDTH  = 256,
    parameter int unsigned BURST_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [LINE_WIDTH-1:0]  line_i,
    output logic [LINE_WIDTH-1:0]  line_o,
    input  logic [ADDR_WIDTH-1:0]  address_i,
    input  logic                   read_i,
    input  logic                   write_i,
    output logic                   resp_o,
    output logic                   busy_o,
    input  logic [BURST_WIDTH-1:0] burst_i,
    output logic [BURST_WIDTH-1:0] burst_o,
    output logic [ADDR_WIDTH-1:0]  address_o,
    output logic                   read_o,
    output logic                   write_o,
    input  logic                   resp_i
);

    localparam int unsigned BEATS = calc_beats(LINE_WIDTH, BURST_WIDTH);
    localparam int unsigned CNT_W = $clog2(BEATS);

    if (!beats_legal(BEATS)) begin : g_bad_params
        $error("line_burst_adaptor: LINE_WIDTH/BURST_WIDTH must be a power of two >= 2");
    end

    state_t                 state;
    logic [CNT_W-1:0]       beat;
    logic [CNT_W-1:0]       beat_nxt;
    logic                   op_write;
    logic                   capture;
    logic                   accept;
    logic                   last_beat;
    logic [LINE_WIDTH-1:0]  cap_line;
    logic [LINE_WIDTH-1:0]  line_nxt;

    assign capture   = (state == IDLE) && (read_i || write_i);
    assign accept    = (state == BURST) && resp_i;
    assign last_beat = (beat == CNT_W'(BEATS - 1));
    assign beat_nxt  = beat + CNT_W'(1);

    // Read line with the current beat's slice replaced by incoming memory data.
    always_comb begin
        line_nxt = line_o;
        line_nxt[32'(beat) * BURST_WIDTH +: BURST_WIDTH] = burst_i;
    end

    en_reg #(.WIDTH(LINE_WIDTH)) u_cap_line (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (capture),
        .d       (line_i),
        .q       (cap_line)
    );

    en_reg #(.WIDTH(ADDR_WIDTH)) u_address (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (capture),
        .d       (address_i),
        .q       (address_o)
    );

    en_reg #(.WIDTH(LINE_WIDTH)) u_line_out (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (accept && !op_write),
        .d       (line_nxt),
        .q       (line_o)
    );

    // Transaction FSM; strobes, beat data and completion pulse are registered alongside the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            beat     <= '0;
            op_write <= 1'b0;
            read_o   <= 1'b0;
            write_o  <= 1'b0;
            burst_o  <= '0;
            resp_o   <= 1'b0;
            busy_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    resp_o <= 1'b0;
                    if (capture) begin
                        state    <= BURST;
                        beat     <= '0;
                        op_write <= write_i;
                        read_o   <= !write_i;
                        write_o  <= write_i;
                        burst_o  <= line_i[BURST_WIDTH-1:0];
                        busy_o   <= 1'b1;
                    end
                end
                BURST: begin
                    if (resp_i) begin
                        beat <= beat_nxt;
                        if (last_beat) begin
                            state   <= DONE;
                            read_o  <= 1'b0;
                            write_o <= 1'b0;
                            burst_o <= '0;
                            resp_o  <= 1'b1;
                        end else begin
                            burst_o <= cap_line[32'(beat_nxt) * BURST_WIDTH +: BURST_WIDTH];
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    resp_o <= 1'b0;
                    busy_o <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    read_o  <= 1'b0;
                    write_o <= 1'b0;
                    burst_o <= '0;
                    resp_o  <= 1'b0;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/line_burst_adaptor.md
LINE_BURST_ADAPTOR -- requirements
Module: line_burst_adaptor

Interface
REQ-001 SHALL have parameter LINE_WIDTH, default 256, cache line width in bits.
REQ-002 SHALL have parameter BURST_WIDTH, default 64, memory beat width in bits.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-004 SHALL derive localparam BEATS = LINE_WIDTH/BURST_WIDTH; elaboration SHALL fail unless BEATS is a power of two and at least 2.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 reset_n  input  1  asynchronous active-low reset.
REQ-008 line_i  input  LINE_WIDTH  write line from cache.
REQ-009 line_o  output  LINE_WIDTH  assembled read line to cache.
REQ-010 address_i  input  ADDR_WIDTH  line address from cache.
REQ-011 read_i  input  1  cache read request.
REQ-012 write_i  input  1  cache write request.
REQ-013 resp_o  output  1  one-cycle completion pulse to cache.
REQ-014 busy_o  output  1  high while a transaction is in flight (BURST or DONE).
REQ-015 burst_i  input  BURST_WIDTH  read beat from memory.
REQ-016 burst_o  output  BURST_WIDTH  write beat to memory.
REQ-017 address_o  output  ADDR_WIDTH  captured line address to memory.
REQ-018 read_o  output  1  memory read strobe.
REQ-019 write_o  output  1  memory write strobe.
REQ-020 resp_i  input  1  memory beat accept/valid.

Function
REQ-021 SHALL implement FSM states IDLE, BURST, DONE plus a beat counter of width $clog2(BEATS).
REQ-022 IDLE: when read_i or write_i is sampled high, SHALL capture address_i, line_i and the operation, clear the beat counter, and go to BURST next cycle.
REQ-023 read_i and write_i both high SHALL be treated as a write.
REQ-024 BURST: SHALL hold read_o high for a read, or write_o high for a write, with burst_o = captured line slice [beat*BURST_WIDTH +: BURST_WIDTH]; in all other cycles burst_o SHALL be 0.
REQ-025 BURST, resp_i high: a read SHALL store burst_i into line_o slice [beat]; the beat counter SHALL increment.
REQ-026 BURST, resp_i low: SHALL hold the state, beat and strobes unchanged (unbounded stall).
REQ-027 resp_i high on beat BEATS-1 SHALL move to DONE; the counter SHALL wrap to 0.
REQ-028 DONE: resp_o SHALL be high for exactly one cycle, read_o/write_o low; next state SHALL be IDLE.
REQ-029 Minimum latency SHALL be BEATS+2 cycles from the request-sample edge to resp_o high, with resp_i held high.
REQ-030 read_i/write_i SHALL be ignored outside IDLE; a request still held high in the IDLE cycle after DONE SHALL start a new transaction.
REQ-031 line_o SHALL update only on read beats and SHALL hold its value across writes and idle time.
REQ-032 address_o SHALL hold the captured address from capture until the next capture.
REQ-033 resp_i in IDLE or DONE SHALL be ignored.

Reset
REQ-034 When reset_n is low, the block SHALL asynchronously enter IDLE and clear beat counter, captured line, line_o, address_o and the operation flag to 0.
REQ-035 During reset resp_o, busy_o, read_o, write_o and burst_o SHALL be 0; a reset mid-burst SHALL abandon the transaction without a resp_o pulse.

Structure
REQ-036 State enum typedef and the BEATS derivation function SHALL live in shared package line_adaptor_pkg.
REQ-037 Captured and assembled storage SHALL use one parametrised sub-module, en_reg (async active-low clear, load enable).

Verification
REQ-038 Read: address_i=0x1000, read_i pulse, resp_i high, burst_i=0x11..,0x22..,0x33..,0x44.. -> read_o high 4 cycles, line_o={0x44..,0x33..,0x22..,0x11..}, resp_o at cycle 6.
REQ-039 Write: line_i=256'h(D3,D2,D1,D0), write_i pulse -> burst_o=D0,D1,D2,D3 on successive resp_i beats, write_o high 4 cycles, one resp_o pulse, line_o unchanged.
REQ-040 Stall: resp_i low 3 cycles before beat 2 -> burst_o/beat held, total latency 9 cycles, data correct.
REQ-041 read_i=write_i=1 together -> write sequence, read_o never high.
REQ-042 reset_n low during beat 2 -> immediate IDLE, all outputs 0, no resp_o; the next read completes normally.
REQ-043 LINE_WIDTH=128, BURST_WIDTH=32 -> 4 beats of 32 bits; LINE_WIDTH=512, BURST_WIDTH=64 -> 8 beats, resp_o at cycle 10.
